// File: rtl/qspi_xip_pkg.sv
// Shared definitions for the QSPI execute-in-place bridge: controller register
// map, CCR field layout, FSM encoding and the CCR builder.
package qspi_xip_pkg;

    localparam logic [7:0] REG_CCR  = 8'h00;
    localparam logic [7:0] REG_ADR  = 8'h04;
    localparam logic [7:0] REG_DATA = 8'h08;

    localparam int CCR_INST_LSB  = 0;
    localparam int CCR_MODE_LSB  = 8;
    localparam int CCR_DIR_BIT   = 10;
    localparam int CCR_DUMMY_LSB = 11;
    localparam int CCR_SIZE_LSB  = 16;
    localparam int CCR_PRESC_LSB = 25;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_SET_ADR = 5'b00010,
        ST_SET_CCR = 5'b00100,
        ST_RD_WORD = 5'b01000,
        ST_RESP    = 5'b10000
    } state_e;

    // Size field holds the transfer byte count minus one; direction 0 = read.
    function automatic logic [31:0] ccr_build(
        input logic [7:0] inst,
        input logic [1:0] mode,
        input logic [4:0] dummy,
        input logic [8:0] size,
        input logic [5:0] prescale
    );
        logic [31:0] v;
        v                          = '0;
        v[CCR_INST_LSB  +: 8]      = inst;
        v[CCR_MODE_LSB  +: 2]      = mode;
        v[CCR_DIR_BIT]             = 1'b0;
        v[CCR_DUMMY_LSB +: 5]      = dummy;
        v[CCR_SIZE_LSB  +: 9]      = size;
        v[CCR_PRESC_LSB +: 6]      = prescale;
        return v;
    endfunction

endpackage

// File: rtl/qspi_xip_line_buf.sv
// Single-line prefetch buffer: word storage, tag, valid flag, hit compare and
// the word-select read mux.
module qspi_xip_line_buf
    import qspi_xip_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2,
    parameter int TAG_W      = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [TAG_W-1:0] i_lookup_tag,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_hit,
    output logic [31:0]      o_rd_dat,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_dat,
    input  logic             i_install,
    input  logic             i_install_valid,
    input  logic [TAG_W-1:0] i_install_tag,
    input  logic             i_inv
);

    logic [31:0]      r_mem [LINE_WORDS];
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;

    // NOTE: storage and tag carry no reset; valid alone decides whether they are trusted.
    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
        if (i_install) begin
            r_tag <= i_install_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
        end else if (i_install) begin
            r_valid <= i_install_valid;
        end else if (i_inv) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit    = r_valid && (r_tag == i_lookup_tag);
    assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/qspi_xip_koprusu.sv
// XIP read bridge: serves CPU word reads from a one-line buffer and refills it
// on a miss by driving the QSPI controller's registers as a Wishbone master.
module qspi_xip_koprusu
    import qspi_xip_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [7:0] INST       = 8'h6B,
    parameter logic [1:0] DATA_MODE  = 2'b11,
    parameter int         DUMMY      = 8,
    parameter int         PRESCALE   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic [23:0] cpu_adr_i,
    output logic        cpu_ack_o,
    output logic [31:0] cpu_dat_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    localparam int               L        = $clog2(LINE_WORDS) + 2;
    localparam int               IDX_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int               TAG_W    = 24 - L;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);
    localparam logic [23:0]      OFS_MASK = 24'(LINE_WORDS * 4 - 1);
    localparam logic [31:0]      CCR_VAL  = ccr_build(INST, DATA_MODE, 5'(DUMMY),
                                                      9'(LINE_WORDS * 4 - 1), 6'(PRESCALE));

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_stb;
    logic             r_we;
    logic [7:0]       r_adr;
    logic [31:0]      r_dat;
    logic             w_stb_nxt;
    logic             w_we_nxt;
    logic [7:0]       w_adr_nxt;
    logic [31:0]      w_dat_nxt;
    logic [IDX_W-1:0] r_word_ctr;
    logic [IDX_W-1:0] r_req_idx;
    logic [23:0]      r_line_base;
    logic             r_flush_pend;
    logic [31:0]      r_cpu_dat;

    logic             w_buf_hit;
    logic [31:0]      w_buf_dat;
    logic             w_hit;
    logic             w_bus_ack;
    logic             w_last;
    logic             w_in_fill;
    logic             w_buf_wr;
    logic             w_buf_inv;
    logic [IDX_W-1:0] w_req_idx;

    // A flush in the same cycle as a request forces a refetch.
    assign w_hit     = w_buf_hit && !flush_i;
    assign w_bus_ack = r_stb && wb_ack_i;
    assign w_last    = (r_word_ctr == IDX_LAST);
    assign w_in_fill = (r_state == ST_SET_ADR) || (r_state == ST_SET_CCR) || (r_state == ST_RD_WORD);
    assign w_buf_wr  = (r_state == ST_RD_WORD) && w_bus_ack;
    assign w_buf_inv = (flush_i && ((r_state == ST_IDLE) || (r_state == ST_RESP)))
                     || ((r_state == ST_IDLE) && cpu_req_i && !w_hit);
    assign w_req_idx = IDX_W'((cpu_adr_i >> 2) & 24'(LINE_WORDS - 1));

    qspi_xip_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_line_buf (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .i_lookup_tag    (cpu_adr_i[23:L]),
        .i_rd_idx        (w_req_idx),
        .o_hit           (w_buf_hit),
        .o_rd_dat        (w_buf_dat),
        .i_wr_en         (w_buf_wr),
        .i_wr_idx        (r_word_ctr),
        .i_wr_dat        (wb_dat_i),
        .i_install       (w_buf_wr && w_last),
        .i_install_valid (!(r_flush_pend || flush_i)),
        .i_install_tag   (r_line_base[23:L]),
        .i_inv           (w_buf_inv)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stb   <= w_stb_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (cpu_req_i) w_state_nxt = w_hit ? ST_RESP : ST_SET_ADR;
            ST_SET_ADR: if (w_bus_ack) w_state_nxt = ST_SET_CCR;
            ST_SET_CCR: if (w_bus_ack) w_state_nxt = ST_RD_WORD;
            ST_RD_WORD: if (w_bus_ack && w_last) w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // A bus state with the strobe low launches its access; an acked access idles one cycle.
    always_comb begin
        w_stb_nxt = r_stb;
        w_we_nxt  = r_we;
        w_adr_nxt = r_adr;
        w_dat_nxt = r_dat;
        if (r_stb) begin
            if (wb_ack_i) w_stb_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_SET_ADR: begin
                    w_stb_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    w_adr_nxt = REG_ADR;
                    w_dat_nxt = {8'h00, r_line_base};
                end
                ST_SET_CCR: begin
                    w_stb_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    w_adr_nxt = REG_CCR;
                    w_dat_nxt = CCR_VAL;
                end
                ST_RD_WORD: begin
                    w_stb_nxt = 1'b1;
                    w_we_nxt  = 1'b0;
                    w_adr_nxt = REG_DATA + 8'({r_word_ctr, 2'b00});
                    w_dat_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_word_ctr   <= '0;
            r_req_idx    <= '0;
            r_line_base  <= '0;
            r_flush_pend <= 1'b0;
            r_cpu_dat    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && cpu_req_i) begin
                r_req_idx    <= w_req_idx;
                r_flush_pend <= 1'b0;
                if (w_hit) r_cpu_dat <= w_buf_dat;
                else       r_line_base <= cpu_adr_i & ~OFS_MASK;
            end
            if (w_in_fill && flush_i) r_flush_pend <= 1'b1;
            if ((r_state == ST_SET_CCR) && w_bus_ack) r_word_ctr <= '0;
            if (w_buf_wr) begin
                r_word_ctr <= r_word_ctr + IDX_W'(1);
                if (r_word_ctr == r_req_idx) r_cpu_dat <= wb_dat_i;
            end
        end
    end

    assign cpu_ack_o = (r_state == ST_RESP);
    assign busy_o    = (r_state != ST_IDLE);
    assign cpu_dat_o = r_cpu_dat;
    assign wb_stb_o  = r_stb;
    assign wb_cyc_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = 4'hF;

endmodule
